flag_branch_unit: RTL and testbench
===================================

// Module: flag_branch_unit
// PURPOSE
//  EX-stage consumer of the 64-bit ALU result. Derives N/Z/C/V, holds the architectural NZCV register and resolves
//  CBZ/B.cond/B. Registers the taken decision into a one-cycle redirect/flush pulse toward IF/ID. Z comes from a
//  balanced 64-input zero-detect tree on the ALU result. CBZ uses a second tree on the forwarded Rt operand.
// PARAMETERS
//  WIDTH     64  datapath width of alu_result / cbz_operand (power of 2, >=2)
//  FLAG_FWD  1   1: B.cond in same cycle as a flag-setting op sees its new flags; 0: sees NZCV register only
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      asynchronous, active-high
//  ex_valid      in   1      EX holds a live (unsquashed) instruction
//  ex_set_flags  in   1      instruction is ADDS/SUBS (updates NZCV)
//  alu_result    in   WIDTH  ALU output
//  alu_carry     in   1      ALU carry-out
//  alu_overflow  in   1      ALU signed overflow
//  br_type       in   2      0 NONE, 1 UNCOND (B), 2 CBZ, 3 BCOND
//  br_cond       in   4      ARMv8 condition code for BCOND
//  cbz_operand   in   WIDTH  forwarded Rt for CBZ
//  nzcv          out  4      architectural flags {N,Z,C,V}
//  redirect      out  1      registered: fetch must load branch target this cycle
//  flush         out  1      registered: squash the instruction currently in IF/ID
//  busy          out  1      high while FSM is in REDIRECT (branches ignored)
// BEHAVIOUR
//  Reset (async, any time): nzcv=4'b0000, redirect=0, flush=0, busy=0, FSM->IDLE. A pending redirect is dropped.
//  Flag derivation (combinational): N=alu_result[WIDTH-1], Z=~|alu_result (via tree), C=alu_carry, V=alu_overflow.
//  NZCV update: on posedge when ex_valid & ex_set_flags & ~busy; otherwise hold.
//  Effective flags for BCOND: FLAG_FWD=1 and ex_set_flags=1 -> live derived flags; else nzcv register.
//   The same instruction may both set flags and be BCOND. This case only occurs in bench stimulus.
//  Condition table: EQ 0 Z | NE 1 ~Z | HS 2 C | LO 3 ~C | MI 4 N | PL 5 ~N | VS 6 V | VC 7 ~V
//   HI 8 C&~Z | LS 9 ~C|Z | GE A N==V | LT B N!=V | GT C ~Z&(N==V) | LE D Z|(N!=V) | AL E 1 | NV F 1.
//  take = ex_valid & ~busy & (UNCOND | (CBZ & cbz_operand==0) | (BCOND & cond_true)). NONE never takes.
//  FSM, 2 states:
//   IDLE: take -> REDIRECT, and redirect and flush assert the following cycle (latency 1). Otherwise stay.
//   REDIRECT: redirect=flush=busy=1 for exactly one cycle, then -> IDLE unconditionally.
//    Any instruction in EX during REDIRECT is the shadow instruction. Its branch is ignored and its flags are NOT written.
//  Back-to-back branches: the second is in the shadow, so it is suppressed. No double redirect is possible.
//  Outputs redirect/flush/busy are flop outputs (glitch-free). nzcv is the register value, never the bypass.
//  ex_valid=0: no flag write, no take, regardless of other inputs (X on data inputs must not propagate).
// STRUCTURE
//  Shared package cpu_pkg: br_type_e enum (BR_NONE/BR_UNCOND/BR_CBZ/BR_BCOND), cond code localparams (COND_EQ..COND_NV),
//   nzcv_t packed struct {n,z,c,v}, fsm state enum (FB_IDLE/FB_REDIRECT).
//  Sub-module zero_detect: parameterised WIDTH, log2(WIDTH)-level 2-input OR tree plus final inverter, output 1 when in==0.
//   Two instances: ALU Z flag and CBZ test.
//  Condition evaluation in a function inside cpu_pkg (cond_holds(nzcv_t, logic[3:0])).
// TESTING
//  1 Reset mid-REDIRECT: take B, assert reset in the next cycle -> redirect/flush/busy drop immediately; nzcv=0000.
//  2 SUBS 5-5 (result 0, C=1, V=0) then B.EQ -> nzcv=0110, redirect=1 one cycle after B.EQ. B.NE at the same point -> no redirect.
//  3 CBZ with cbz_operand=64'h0 -> redirect. CBZ with 64'h8000_0000_0000_0000 -> no redirect (MSB-only nonzero caught).
//  4 Two consecutive B in EX -> exactly one redirect pulse; busy=1 in the second cycle.
//    A SUBS in the shadow does not change nzcv.
//  5 FLAG_FWD=1: SUBS 3-7 (N=1,V=0) with same-cycle B.LT -> taken. FLAG_FWD=0 with nzcv=0000 -> not taken.
//  6 All 16 cond codes against all 16 nzcv values (256 cases) vs reference table; NV and AL always taken.
//    ex_valid=0 with B -> no redirect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: branch kinds, ARMv8 condition codes, the NZCV flag
// record, the flag/branch FSM states and the condition evaluator.
package cpu_pkg;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_UNCOND = 2'd1,
    BR_CBZ    = 2'd2,
    BR_BCOND  = 2'd3
  } br_type_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic {
    FB_IDLE     = 1'b0,
    FB_REDIRECT = 1'b1
  } fb_state_e;

  // ARMv8 condition evaluation; AL and NV both always hold.
  function automatic logic cond_holds(input nzcv_t f, input logic [3:0] cond);
    logic r;
    case (cond)
      COND_EQ: r = f.z;
      COND_NE: r = ~f.z;
      COND_HS: r = f.c;
      COND_LO: r = ~f.c;
      COND_MI: r = f.n;
      COND_PL: r = ~f.n;
      COND_VS: r = f.v;
      COND_VC: r = ~f.v;
      COND_HI: r = f.c & ~f.z;
      COND_LS: r = ~f.c | f.z;
      COND_GE: r = (f.n == f.v);
      COND_LT: r = (f.n != f.v);
      COND_GT: r = ~f.z & (f.n == f.v);
      COND_LE: r = f.z | (f.n != f.v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/zero_detect.sv
// Balanced zero detector: log2(WIDTH) levels of 2-input ORs, then an inverter.
// Nodes are stored heap-style: node[i] = node[2i+1] | node[2i+2], leaves at
// WIDTH-1 .. 2*WIDTH-2. WIDTH must be a power of two so every leaf sits at
// the same depth.
module zero_detect #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] in_data,
  output logic             is_zero
);

  logic node [0:2*WIDTH-2];

  // Leaves of the OR tree
  for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
    assign node[WIDTH-1+i] = in_data[i];
  end

  // Internal OR nodes
  for (genvar i = 0; i < WIDTH-1; i++) begin : g_node
    assign node[i] = node[2*i+1] | node[2*i+2];
  end

  assign is_zero = ~node[0];

endmodule

// File: rtl/flag_branch_unit.sv
// EX-stage flag and branch unit: derives NZCV from the ALU result, holds the
// architectural flag register, resolves B / CBZ / B.cond and turns a taken
// branch into a registered one-cycle redirect/flush pulse.
module flag_branch_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter bit FLAG_FWD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_set_flags,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic [1:0]       br_type,
  input  logic [3:0]       br_cond,
  input  logic [WIDTH-1:0] cbz_operand,
  output logic [3:0]       nzcv,
  output logic             redirect,
  output logic             flush,
  output logic             busy
);

  logic      alu_zero;
  logic      cbz_zero;
  nzcv_t     live_flags;
  nzcv_t     eff_flags;
  nzcv_t     nzcv_d, nzcv_q;
  fb_state_e state_d, state_q;
  br_type_e  br;
  logic      take;

  zero_detect #(.WIDTH(WIDTH)) u_alu_zero (
    .in_data (alu_result),
    .is_zero (alu_zero)
  );

  zero_detect #(.WIDTH(WIDTH)) u_cbz_zero (
    .in_data (cbz_operand),
    .is_zero (cbz_zero)
  );

  assign br = br_type_e'(br_type);

  // Flags produced by the instruction now in EX, and the set B.cond looks at
  always_comb begin
    live_flags = '{n: alu_result[WIDTH-1], z: alu_zero, c: alu_carry, v: alu_overflow};
    eff_flags  = (FLAG_FWD && ex_set_flags) ? live_flags : nzcv_q;
  end

  // Branch resolution; shadow and invalid instructions never take
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    take = 1'b0;
    if (ex_valid && (state_q == FB_IDLE)) begin
      case (br)
        BR_UNCOND: take = 1'b1;
        BR_CBZ:    take = cbz_zero;
        BR_BCOND:  take = cond_holds(eff_flags, br_cond);
        default:   take = 1'b0;
      endcase
    end
  end

  // Next NZCV: written only by a live flag-setting op outside the shadow
  always_comb begin
    nzcv_d = nzcv_q;
    if (ex_valid && ex_set_flags && (state_q == FB_IDLE)) begin
      nzcv_d = live_flags;
    end
  end

  // Next FSM state: REDIRECT lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      FB_IDLE:     if (take) state_d = FB_REDIRECT;
      FB_REDIRECT: state_d = FB_IDLE;
      default:     state_d = FB_IDLE;
    endcase
  end

  // State and flag registers; reset drops any pending redirect
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (reset) begin
      state_q <= FB_IDLE;
      nzcv_q  <= '0;
    end else begin
      state_q <= state_d;
      nzcv_q  <= nzcv_d;
    end
  end

  assign nzcv     = nzcv_q;
  assign redirect = (state_q == FB_REDIRECT);
  assign flush    = (state_q == FB_REDIRECT);
  assign busy     = (state_q == FB_REDIRECT);

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit. Two instances share the stimulus:
// dut_f (FLAG_FWD=1) and dut_n (FLAG_FWD=0).
module tb_flag_branch_unit;
  import cpu_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         ex_valid;
  logic         ex_set_flags;
  logic [W-1:0] alu_result;
  logic         alu_carry;
  logic         alu_overflow;
  logic [1:0]   br_type;
  logic [3:0]   br_cond;
  logic [W-1:0] cbz_operand;

  logic [3:0] nzcv_f, nzcv_n;
  logic       redirect_f, flush_f, busy_f;
  logic       redirect_n, flush_n, busy_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flag_branch_unit #(.WIDTH(W), .FLAG_FWD(1'b1)) dut_f (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .br_type(br_type), .br_cond(br_cond), .cbz_operand(cbz_operand),
    .nzcv(nzcv_f), .redirect(redirect_f), .flush(flush_f), .busy(busy_f)
  );

  flag_branch_unit #(.WIDTH(W), .FLAG_FWD(1'b0)) dut_n (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .br_type(br_type), .br_cond(br_cond), .cbz_operand(cbz_operand),
    .nzcv(nzcv_n), .redirect(redirect_n), .flush(flush_n), .busy(busy_n)
  );

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_valid     = 1'b0;
    ex_set_flags = 1'b0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    br_type      = BR_NONE;
    br_cond      = 4'h0;
    cbz_operand  = '1;
  endtask

  task automatic drive_subs(input logic [W-1:0] res, input logic c, input logic v);
    ex_valid     = 1'b1;
    ex_set_flags = 1'b1;
    alu_result   = res;
    alu_carry    = c;
    alu_overflow = v;
    br_type      = BR_NONE;
  endtask

  task automatic drive_branch(input logic [1:0] bt, input logic [3:0] cc);
    ex_valid     = 1'b1;
    ex_set_flags = 1'b0;
    br_type      = bt;
    br_cond      = cc;
  endtask

  // Reference condition table, written from the ARMv8 definitions.
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] cc);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    n_cmp++;
    if ({nzcv_f, redirect_f, flush_f, busy_f} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_state_f: got %b want 0000000", {nzcv_f, redirect_f, flush_f, busy_f});
    end
    n_cmp++;
    if ({nzcv_n, redirect_n, flush_n, busy_n} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_state_n: got %b want 0000000", {nzcv_n, redirect_n, flush_n, busy_n});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_subs_beq();
    drive_subs(64'd0, 1'b1, 1'b0);  // SUBS 5-5
    tick();
    n_cmp++;
    if (nzcv_f !== 4'b0110 || nzcv_n !== 4'b0110) begin
      n_bad++;
      $display("FAIL subs_nzcv: got f=%b n=%b want 0110", nzcv_f, nzcv_n);
    end
    n_cmp++;
    if (redirect_f !== 1'b0) begin
      n_bad++;
      $display("FAIL subs_no_redirect: got %b want 0", redirect_f);
    end
    drive_branch(BR_BCOND, COND_EQ);
    tick();
    n_cmp++;
    if ({redirect_f, flush_f, busy_f, redirect_n, flush_n, busy_n} !== 6'b111111) begin
      n_bad++;
      $display("FAIL beq_taken: got %b want 111111",
               {redirect_f, flush_f, busy_f, redirect_n, flush_n, busy_n});
    end
    drive_idle();
    tick();
    n_cmp++;
    if ({redirect_f, flush_f, busy_f} !== 3'b000) begin
      n_bad++;
      $display("FAIL beq_pulse_end: got %b want 000", {redirect_f, flush_f, busy_f});
    end
    drive_branch(BR_BCOND, COND_NE);
    tick();
    n_cmp++;
    if (redirect_f !== 1'b0 || redirect_n !== 1'b0) begin
      n_bad++;
      $display("FAIL bne_not_taken: got f=%b n=%b want 0", redirect_f, redirect_n);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid_redirect();
    drive_branch(BR_UNCOND, 4'h0);
    tick();
    n_cmp++;
    if ({redirect_f, flush_f, busy_f} !== 3'b111) begin
      n_bad++;
      $display("FAIL b_before_reset: got %b want 111", {redirect_f, flush_f, busy_f});
    end
    drive_idle();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({nzcv_f, redirect_f, flush_f, busy_f} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_async_drop: got %b want 0000000", {nzcv_f, redirect_f, flush_f, busy_f});
    end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({redirect_f, flush_f, busy_f} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_pending_dropped: got %b want 000", {redirect_f, flush_f, busy_f});
    end
  endtask

  task automatic test_cbz();
    drive_branch(BR_CBZ, 4'h0);
    cbz_operand = 64'h0;
    alu_result  = 64'h1234;
    tick();
    n_cmp++;
    if ({redirect_f, flush_f, busy_f} !== 3'b111) begin
      n_bad++;
      $display("FAIL cbz_zero_taken: got %b want 111", {redirect_f, flush_f, busy_f});
    end
    drive_idle();
    tick();
    drive_branch(BR_CBZ, 4'h0);
    cbz_operand = 64'h8000_0000_0000_0000;
    alu_result  = 64'h0;
    tick();
    n_cmp++;
    if (redirect_f !== 1'b0 || redirect_n !== 1'b0) begin
      n_bad++;
      $display("FAIL cbz_msb_not_taken: got f=%b n=%b want 0", redirect_f, redirect_n);
    end
    drive_branch(BR_CBZ, 4'h0);
    cbz_operand = 64'h0000_0000_0000_0001;
    tick();
    n_cmp++;
    if (redirect_f !== 1'b0) begin
      n_bad++;
      $display("FAIL cbz_lsb_not_taken: got %b want 0", redirect_f);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    // nzcv is 0000 after the mid-redirect reset.
    drive_branch(BR_UNCOND, 4'h0);
    tick();
    n_cmp++;
    if ({redirect_f, flush_f, busy_f} !== 3'b111) begin
      n_bad++;
      $display("FAIL b2b_first: got %b want 111", {redirect_f, flush_f, busy_f});
    end
    // Shadow instruction: another B that is also a flag-setting op.
    drive_branch(BR_UNCOND, 4'h0);
    ex_set_flags = 1'b1;
    alu_result   = 64'd0;
    alu_carry    = 1'b1;
    tick();
    n_cmp++;
    if ({redirect_f, flush_f, busy_f, redirect_n} !== 4'b0000) begin
      n_bad++;
      $display("FAIL b2b_second_suppressed: got %b want 0000", {redirect_f, flush_f, busy_f, redirect_n});
    end
    n_cmp++;
    if (nzcv_f !== 4'b0000 || nzcv_n !== 4'b0000) begin
      n_bad++;
      $display("FAIL shadow_subs_nzcv: got f=%b n=%b want 0000", nzcv_f, nzcv_n);
    end
    drive_idle();
    tick();
    n_cmp++;
    if (redirect_f !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_no_late_pulse: got %b want 0", redirect_f);
    end
  endtask

  task automatic test_flag_fwd();
    drive_subs(64'd1, 1'b1, 1'b0);  // loads nzcv = 0010
    tick();
    drive_subs(64'd0, 1'b0, 1'b0);
    alu_result = 64'd1;             // loads nzcv = 0000
    tick();
    n_cmp++;
    if (nzcv_f !== 4'b0000 || nzcv_n !== 4'b0000) begin
      n_bad++;
      $display("FAIL fwd_preload: got f=%b n=%b want 0000", nzcv_f, nzcv_n);
    end
    // SUBS 3-7 = -4: N=1 Z=0 C=0 V=0, with B.LT in the same instruction.
    drive_subs(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    br_type = BR_BCOND;
    br_cond = COND_LT;
    tick();
    n_cmp++;
    if (redirect_f !== 1'b1) begin
      n_bad++;
      $display("FAIL fwd_blt_taken: got %b want 1", redirect_f);
    end
    n_cmp++;
    if (redirect_n !== 1'b0) begin
      n_bad++;
      $display("FAIL nofwd_blt_not_taken: got %b want 0", redirect_n);
    end
    n_cmp++;
    if (nzcv_f !== 4'b1000 || nzcv_n !== 4'b1000) begin
      n_bad++;
      $display("FAIL fwd_nzcv: got f=%b n=%b want 1000", nzcv_f, nzcv_n);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_cond_table();
    logic [3:0] last_f;
    logic       exp;
    logic       got;
    last_f = nzcv_f === 4'b1000 ? 4'b1000 : 4'bxxxx;
    for (int f = 0; f < 16; f++) begin
      for (int cc = 0; cc < 16; cc++) begin
        exp = ref_cond(4'(f), 4'(cc));
        if (f[3] && f[2]) begin
          // N=1,Z=1 cannot come out of an ALU result; check the evaluator alone.
          got = cond_holds(nzcv_t'(4'(f)), 4'(cc));
          n_cmp++;
          if (got !== exp) begin
            n_bad++;
            $display("FAIL cond_fn f=%h cc=%h: got %b want %b", f, cc, got, exp);
          end
        end else begin
          drive_subs(f[2] ? 64'd0 : (f[3] ? 64'h8000_0000_0000_0001 : 64'd1), f[1], f[0]);
          br_type = BR_BCOND;
          br_cond = 4'(cc);
          tick();
          n_cmp++;
          if (redirect_f !== exp) begin
            n_bad++;
            $display("FAIL cond_dut f=%h cc=%h: got %b want %b", f, cc, redirect_f, exp);
          end
          if (cc == 0) begin
            n_cmp++;
            if (nzcv_f !== 4'(f)) begin
              n_bad++;
              $display("FAIL cond_nzcv f=%h: got %b want %b", f, nzcv_f, 4'(f));
            end
          end
          last_f = 4'(f);
          drive_idle();
          tick();
        end
      end
    end
    // ex_valid=0 with B and X data: no redirect, no flag write.
    drive_idle();
    br_type      = BR_UNCOND;
    ex_set_flags = 1'b1;
    alu_result   = 'x;
    alu_carry    = 1'bx;
    alu_overflow = 1'bx;
    br_cond      = 4'bx;
    cbz_operand  = 'x;
    tick();
    n_cmp++;
    if (redirect_f !== 1'b0 || redirect_n !== 1'b0) begin
      n_bad++;
      $display("FAIL invalid_b_redirect: got f=%b n=%b want 0", redirect_f, redirect_n);
    end
    n_cmp++;
    if (nzcv_f !== last_f || nzcv_n !== last_f) begin
      n_bad++;
      $display("FAIL invalid_nzcv_hold: got f=%b n=%b want %b", nzcv_f, nzcv_n, last_f);
    end
    drive_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_subs_beq();
    test_reset_mid_redirect();
    test_cbz();
    test_back_to_back();
    test_flag_fwd();
    test_cond_table();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
